itrx_apb_mstr_arb: RTL
======================

Name: itrx_apb_mstr_arb

Overview:
- Round-robin arbiter and sequencer that shares one APB master port between NREQ on-chip requesters.
- Each requester presents a single read/write command; the block grants one, runs the APB SETUP/ACCESS sequence, and returns the read data or error with a one-cycle ack.
- Sits between internal control engines and the peripheral APB fabric.
- Transfer direction uses itrx_amba2_apb_pkg::te_pwrite (READ=0, WRITE=1).

Parameters:
- NREQ, 4, number of requesters (2..16).
- AW, 32, APB address width.
- DW, 32, APB data width.
- TIMEOUT_CYC, 256, ACCESS-phase wait limit; used only with the optional feature.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous reset, active-high
- req_vld  in  NREQ  per-requester command valid; held until req_ack
- req_wr  in  NREQ  per-requester direction, te_pwrite encoding
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data
- req_ack  out  NREQ  one-hot completion pulse
- req_gnt  out  NREQ  one-hot registered current owner
- rsp_rdata  out  DW  read data, valid with req_ack
- rsp_err  out  1  slave/timeout error, valid with req_ack
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  te_pwrite
- paddr  out  AW  APB address
- pwdata  out  DW  APB write data
- prdata  in  DW  APB read data
- pready  in  1  APB ready; tie 1 for AMBA2 slaves
- pslverr  in  1  APB error; tie 0 if unused

Behaviour:
- Reset values (asynchronous, immediate): psel=0, penable=0, pwrite=READ, paddr=0, pwdata=0, req_gnt=0, RR pointer=0, FSM=IDLE.
- FSM has three states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_vld is set, grant the first set requester at or after index ptr+1 mod NREQ.
  - Register req_gnt, pwrite, paddr, pwdata from the winner. Go to SETUP.
  - Otherwise stay in IDLE.
- SETUP: psel=1, penable=0. Always go to ACCESS next cycle.
- ACCESS:
  - psel=1, penable=1.
  - If pready=0, hold; paddr, pwdata and pwrite stay stable.
  - If pready=1, this is the completion cycle. Go to IDLE and set ptr to the granted index.
- Completion cycle outputs:
  - req_ack[gnt] is combinational: ACCESS && pready.
  - rsp_rdata=prdata; rsp_err=pslverr.
  - Outside the completion cycle req_ack=0, rsp_rdata=0, rsp_err=0.
- Cycle after completion: FSM is in IDLE, psel=0, req_gnt=0. The requester must drop or replace req_vld in this cycle.
  - The just-acked requester has lowest priority in this arbitration (ptr rule).
- Minimum latency: req_vld sampled in IDLE at cycle 0 → psel at cycle 1 → penable at cycle 2 → ack at cycle 2 with pready=1.
  - Back-to-back throughput is 3 cycles per transfer.
- Simultaneous requests: resolved purely by RR order. With ptr at reset 0, requester 1 wins first when all are asserted.
- req_vld deasserted mid-transfer: ignored. The transfer completes and ack still pulses.
- Changes to req_addr, req_wdata or req_wr after grant have no effect on the current transfer.
- pslverr=1 on a write: the transfer completes normally with rsp_err=1. No retry.
- Reset asserted mid-transfer: APB outputs drop immediately, no ack is issued, and the pointer returns to 0.
- NREQ=1: the winner is always index 0.

Optional Feature:
- Macro: ITRX_APB_ARB_TIMEOUT_EN.
- When defined:
  - An internal counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYC-1 with pready still 0, the block forces completion that cycle: req_ack pulses, rsp_err=1, rsp_rdata=0, FSM goes to IDLE.
  - Counter width is $clog2(TIMEOUT_CYC)+1.
- When undefined: no counter exists, and ACCESS waits on pready indefinitely.

Test Plan:
- Single read: req_vld[2]=1, req_wr=READ, addr 0x40, pready=1, prdata 0xA5A5_0001 → psel at cycle 1, penable at cycle 2, req_ack=4'b0100 with rsp_rdata=0xA5A5_0001 and rsp_err=0 at cycle 2.
- Round-robin: all four requesters issue continuous writes, pready=1 → grant order 1,2,3,0,1; acks spaced 3 cycles apart; each paddr matches its owner.
- Wait states: write 0x1234_5678 to 0x10, pready low for 5 ACCESS cycles → paddr and pwdata stable for 6 ACCESS cycles; ack in the 6th; total latency 7 cycles.
- Slave error: read with pslverr=1 in the completion cycle → rsp_err=1, ack pulses, next arbitration proceeds normally.
- Reset mid-ACCESS: assert rst during a held ACCESS → psel and penable drop the same cycle, no ack. After release, the pending req_vld[0] is granted first from ptr 0.
- Timeout (macro on, TIMEOUT_CYC=8): pready tied 0 → ack in the 8th ACCESS cycle with rsp_err=1 and rsp_rdata=0. Macro off → no ack after 100 cycles.

Source files
------------

// File: rtl/itrx_apb_mstr_arb.sv
// Round-robin arbiter that shares one APB master port between NREQ requesters.
// Optional ACCESS-phase timeout: define ITRX_APB_ARB_TIMEOUT_EN.

package itrx_amba2_apb_pkg;
    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } te_pwrite;
endpackage

module itrx_apb_mstr_arb
    import itrx_amba2_apb_pkg::*;
#(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_vld_i,
    input  logic [NREQ-1:0]    req_wr_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*DW-1:0] req_wdata_i,
    output logic [NREQ-1:0]    req_ack_o,
    output logic [NREQ-1:0]    req_gnt_o,
    output logic [DW-1:0]      rsp_rdata_o,
    output logic               rsp_err_o,
    output logic               psel_o,
    output logic               penable_o,
    output logic               pwrite_o,
    output logic [AW-1:0]      paddr_o,
    output logic [DW-1:0]      pwdata_o,
    input  logic [DW-1:0]      prdata_i,
    input  logic               pready_i,
    input  logic               pslverr_i
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e          state_q;
    logic [NREQ-1:0] gnt_q;
    logic [IW-1:0]   gnt_idx_q;
    logic [IW-1:0]   ptr_q;
    logic            psel_q;
    logic            penable_q;
    te_pwrite        pwrite_q;
    logic [AW-1:0]   paddr_q;
    logic [DW-1:0]   pwdata_q;

    logic            win_vld;
    logic [IW-1:0]   win_idx;
    int unsigned     cand;
    logic [IW-1:0]   cand_idx;
    te_pwrite        win_wr;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;

    logic            tmo_hit;
    logic            done;

    // Search starts one past the last owner, so the just-served requester is considered last.
    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IW'(cand);
            if (!win_vld && req_vld_i[cand_idx]) begin
                win_vld = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    always_comb begin
        win_wr    = READ;
        win_addr  = '0;
        win_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_idx == IW'(i)) begin
                win_wr    = te_pwrite'(req_wr_i[i]);
                win_addr  = req_addr_i[i*AW +: AW];
                win_wdata = req_wdata_i[i*DW +: DW];
            end
        end
    end

`ifdef ITRX_APB_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;

    logic [TW-1:0] tmo_cnt_q;

    assign tmo_hit = (state_q == ACCESS) && !pready_i && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if (state_q == SETUP) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ACCESS && !pready_i) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign done = (state_q == ACCESS) && (pready_i || tmo_hit);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            ptr_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= READ;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        state_q   <= SETUP;
                        gnt_q     <= NREQ'(1) << win_idx;
                        gnt_idx_q <= win_idx;
                        pwrite_q  <= win_wr;
                        paddr_q   <= win_addr;
                        pwdata_q  <= win_wdata;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    if (done) begin
                        state_q   <= IDLE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        gnt_q     <= '0;
                        ptr_q     <= gnt_idx_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Completion outputs are combinational so the ack lands in the same cycle as pready.
    assign req_ack_o   = done ? gnt_q : '0;
    assign rsp_rdata_o = (state_q == ACCESS && pready_i) ? prdata_i : '0;
    assign rsp_err_o   = (state_q == ACCESS) && (pready_i ? pslverr_i : tmo_hit);

    assign req_gnt_o = gnt_q;
    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign pwrite_o  = pwrite_q;
    assign paddr_o   = paddr_q;
    assign pwdata_o  = pwdata_q;

endmodule
